// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch queue.
// Widths match the CPU's instruction bus.
package fetch_pkg;

  localparam int CPU_ADDR_W = 9;
  localparam int CPU_DATA_W = 16;

  localparam logic [CPU_DATA_W-1:0] NOP_INST = '0;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [CPU_DATA_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: memory request/response, redirect and decode handshake.
// master is the queue side, slave is the surrounding pipeline.
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] mem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic [CW-1:0]     count;

  modport master (
    input  flush, flush_pc, mem_data, out_ready,
    output req_valid, req_addr, out_valid,
    output out_inst, out_pc, count
  );

  modport slave (
    output flush, flush_pc, mem_data, out_ready,
    input  req_valid, req_addr, out_valid,
    input  out_inst, out_pc, count
  );

endinterface

// File: rtl/fq_storage.sv
// Register array for queued {pc, inst} entries.
// Synchronous write, asynchronous read, no reset.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fq_entry_t,
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [PW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns fetch PC, issues reads,
// buffers responses for decode, flushes on redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) (
  input logic         clk,
  input logic         reset,
  fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic              resp_pending;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [OW-1:0]     occ;
  logic              valid;
  logic              pop;
  logic              push;
  logic              issue;
  entry_t            wdata;
  entry_t            rdata;

  assign valid = (count != '0);
  assign pop   = valid & bus.out_ready & ~bus.flush;
  assign push  = resp_pending & ~bus.flush;

  // Slots already committed plus the one in flight, with pop credit.
  assign occ   = OW'(count) + OW'(resp_pending) - OW'(pop);
  assign issue = ~reset & ~bus.flush & (occ < OW'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc     <= '0;
      resp_pc      <= '0;
      resp_pending <= 1'b0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
    end else if (bus.flush) begin
      fetch_pc     <= bus.flush_pc;
      resp_pending <= 1'b0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
    end else begin
      resp_pending <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + 1'b1;
        resp_pc  <= fetch_pc;
      end
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign wdata = '{pc: resp_pc, inst: bus.mem_data};

  fq_storage #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (tail),
    .wdata (wdata),
    .raddr (head),
    .rdata (rdata)
  );

  assign bus.req_valid = issue;
  assign bus.req_addr  = fetch_pc;
  assign bus.out_valid = valid;
  assign bus.out_inst  = valid ? rdata.inst : DATA_W'(NOP_INST);
  assign bus.out_pc    = valid ? rdata.pc : '0;
  assign bus.count     = count;

  a_no_push_full: assert property (
    @(posedge clk) disable iff (reset)
    !(push && count == CW'(DEPTH))
  );

  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (reset)
    !(pop && count == '0)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-level model.
// Two instances: DEPTH=4/ADDR_W=9 and DEPTH=2/ADDR_W=12.
module tb_fetch_queue;

  logic clk;
  logic rst_a;
  logic rst_b;

  fetch_queue_if #(.ADDR_W(9),  .DATA_W(16), .DEPTH(4)) ifa ();
  fetch_queue_if #(.ADDR_W(12), .DATA_W(16), .DEPTH(2)) ifb ();

  fetch_queue #(.DEPTH(4), .ADDR_W(9), .DATA_W(16)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa.master)
  );

  fetch_queue #(.DEPTH(2), .ADDR_W(12), .DATA_W(16)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: inst = addr + 0x100, garbage when no request.
  always @(posedge clk) begin
    ifa.mem_data <= ifa.req_valid ?
      16'(ifa.req_addr) + 16'h100 : 16'($urandom);
    ifb.mem_data <= ifb.req_valid ?
      16'(ifb.req_addr) + 16'h100 : 16'($urandom);
  end

  int sel;
  int n_chk;
  int n_fail;

  logic [31:0] o_rv, o_ra, o_ov, o_pc, o_in, o_cnt;
  assign o_rv  = sel != 0 ? 32'(ifb.req_valid) : 32'(ifa.req_valid);
  assign o_ra  = sel != 0 ? 32'(ifb.req_addr)  : 32'(ifa.req_addr);
  assign o_ov  = sel != 0 ? 32'(ifb.out_valid) : 32'(ifa.out_valid);
  assign o_pc  = sel != 0 ? 32'(ifb.out_pc)    : 32'(ifa.out_pc);
  assign o_in  = sel != 0 ? 32'(ifb.out_inst)  : 32'(ifa.out_inst);
  assign o_cnt = sel != 0 ? 32'(ifb.count)     : 32'(ifa.count);

  // Model: buffered pcs, one in-flight read, next fetch address.
  int depth;
  int amask;
  int q[$];
  bit pend;
  int pend_pc;
  int fpc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit f, input int fp,
                      input bit rdy);
    bit pop_m;
    bit iss_m;
    int sz;
    int hp;
    if (sel == 0) rst_a = r;
    else rst_b = r;
    ifa.flush     = f;
    ifb.flush     = f;
    ifa.flush_pc  = 9'(fp);
    ifb.flush_pc  = 12'(fp);
    ifa.out_ready = rdy;
    ifb.out_ready = rdy;
    #1;
    if (r) begin
      q.delete();
      pend = 1'b0;
      fpc  = 0;
    end
    sz    = q.size();
    hp    = (sz != 0) ? q[0] : 0;
    pop_m = !r && sz > 0 && rdy && !f;
    iss_m = !r && !f && (sz + int'(pend) - int'(pop_m) < depth);
    chk("req_valid", o_rv, 32'(iss_m));
    chk("req_addr", o_ra, fpc);
    chk("out_valid", o_ov, 32'(sz != 0));
    chk("out_pc", o_pc, hp);
    chk("out_inst", o_in, (sz != 0) ? ((hp + 'h100) & 'hFFFF) : 0);
    chk("count", o_cnt, sz);
    @(posedge clk);
    if (!r) begin
      if (f) begin
        q.delete();
        pend = 1'b0;
        fpc  = fp & amask;
      end else begin
        if (pop_m) void'(q.pop_front());
        if (pend) q.push_back(pend_pc);
        pend = iss_m;
        if (iss_m) begin
          pend_pc = fpc;
          fpc     = (fpc + 1) & amask;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_run(input int n, input int rst_pct);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 99) < rst_pct,
           $urandom_range(0, 19) == 0,
           int'($urandom),
           $urandom_range(0, 9) < 7);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    sel    = 0;
    depth  = 4;
    amask  = 'h1FF;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    ifa.flush = 1'b0; ifa.flush_pc = '0; ifa.out_ready = 1'b0;
    ifb.flush = 1'b0; ifb.flush_pc = '0; ifb.out_ready = 1'b0;
    @(negedge clk);

    // Reset, then free-running stream.
    repeat (2) step(1, 0, 0, 1);
    repeat (12) step(0, 0, 0, 1);

    // Back-pressure until full, then drain.
    step(1, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    repeat (8) step(0, 0, 0, 1);

    // Flush with count=3 and a response in flight.
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 1, 'h40, 1);
    repeat (8) step(0, 0, 0, 1);

    // PC wrap at the top of the address space.
    step(0, 1, 'h1FE, 1);
    repeat (8) step(0, 0, 0, 1);

    // Asynchronous reset mid-stream with count=2.
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (8) step(0, 0, 0, 1);

    rand_run(300, 1);

    // Minimal-depth instance with wider addresses.
    rst_a = 1'b1;
    sel   = 1;
    depth = 2;
    amask = 'hFFF;
    repeat (2) step(1, 0, 0, 1);
    repeat (8) step(0, 0, 0, 1);
    step(0, 1, 'hFFE, 1);
    repeat (6) step(0, 0, 0, 1);
    rand_run(400, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
